uart_cmd_decoder: RTL

Byte-stream command decoder sitting directly downstream of the `uart` receiver and upstream of its transmitter. It consumes received bytes (`data_o`/`ack_o` of `uart`), assembles checksummed register read/write packets, and drives a simple single-cycle register bus. It emits response bytes back through the `uart` transmit strobe (`data_i`/`ack_i`). It replaces the LED-latch test path with a host-controllable register port.

---
 rtl/uart_cmd_decoder_pkg.sv | 25 ++
 rtl/uart_cmd_decoder_if.sv | 25 ++
 rtl/uart_cmd_decoder_tx_pacer.sv | 55 +++++
 rtl/uart_cmd_decoder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_decoder_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART command decoder.
package uart_cmd_pkg;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;

   localparam logic [7:0] RSP_OK   = 8'h4B;
   localparam logic [7:0] RSP_DATA = 8'h44;
   localparam logic [7:0] RSP_ERR  = 8'h45;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DATA   = 3'd2,
      ST_CSUM   = 3'd3,
      ST_EXEC   = 3'd4,
      ST_RDWAIT = 3'd5,
      ST_RESP   = 3'd6
   } state_e;

   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_WRITE) || (b == OP_READ);
   endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte stream, response strobe and register bus between the uart and the command decoder.
interface uart_cmd_decoder_if;

   logic [7:0] rx_data_i;
   logic       rx_ack_i;
   logic [7:0] tx_data_o;
   logic       tx_ack_o;
   logic [7:0] reg_addr_o;
   logic [7:0] reg_wdata_o;
   logic       reg_we_o;
   logic       reg_re_o;
   logic [7:0] reg_rdata_i;
   logic       busy_o;

   modport slave (
      input  rx_data_i, rx_ack_i, reg_rdata_i,
      output tx_data_o, tx_ack_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, busy_o
   );

   modport master (
      output rx_data_i, rx_ack_i, reg_rdata_i,
      input  tx_data_o, tx_ack_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, busy_o
   );

endinterface

// File: rtl/uart_cmd_decoder_tx_pacer.sv
// uart_tx_pacer: 2-entry response byte queue; strobe the cycle after a push, then one per TX_GAP_CYCLES.
// No backpressure exists on the uart side, so spacing is enforced purely by the gap counter.
module uart_tx_pacer #(
   parameter int TX_GAP_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_vld,
   input  logic       push_two,
   input  logic [7:0] push_b0,
   input  logic [7:0] push_b1,
   output logic       tx_vld,
   output logic [7:0] tx_dat,
   output logic       idle
);

   localparam int GW = (TX_GAP_CYCLES > 1) ? $clog2(TX_GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(TX_GAP_CYCLES - 1);

   logic [7:0]    q [2];
   logic [1:0]    q_cnt;
   logic [GW-1:0] gap_cnt;
   logic          gap_done;

   assign gap_done = (gap_cnt == '0);
   assign tx_vld   = (q_cnt != 2'd0) && gap_done;
   assign tx_dat   = q[0];
   assign idle     = (q_cnt == 2'd0) && gap_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q[0]    <= '0;
         q[1]    <= '0;
         q_cnt   <= '0;
         gap_cnt <= '0;
      end else begin
         if (tx_vld) begin
            gap_cnt <= GAP_LOAD;
         end else if (!gap_done) begin
            gap_cnt <= gap_cnt - 1'b1;
         end

         // The decoder only pushes while the pacer is idle, so a push never meets a pop.
         if (push_vld) begin
            q[0]  <= push_b0;
            q[1]  <= push_b1;
            q_cnt <= push_two ? 2'd2 : 2'd1;
         end else if (tx_vld) begin
            q[0]  <= q[1];
            q_cnt <= q_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Checksummed 'W'/'R' packet decoder driving a single-cycle register bus and answering K/D/E.
// Bus strobe 1 cycle after a good csum; bytes arriving while executing or responding are dropped.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 5_000_000,
   parameter int TX_GAP_CYCLES  = 5000
) (
   input  logic                clk,
   input  logic                rst,
   uart_cmd_decoder_if.slave   bus
);

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_ADDR   = ST_ADDR;
   localparam logic [2:0] S_DATA   = ST_DATA;
   localparam logic [2:0] S_CSUM   = ST_CSUM;
   localparam logic [2:0] S_EXEC   = ST_EXEC;
   localparam logic [2:0] S_RDWAIT = ST_RDWAIT;
   localparam logic [2:0] S_RESP   = ST_RESP;

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]    state;
   logic          is_write;
   logic [7:0]    csum_acc;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_exp;
   logic          in_pkt;
   logic [7:0]    reg_addr;
   logic [7:0]    reg_wdata;
   logic          reg_we;
   logic          reg_re;

   logic          push_vld;
   logic          push_two;
   logic [7:0]    push_b0;
   logic [7:0]    push_b1;
   logic          tx_vld;
   logic [7:0]    tx_dat;
   logic          tx_idle;

   assign in_pkt  = (state == S_ADDR) || (state == S_DATA) || (state == S_CSUM);
   assign tmo_exp = (tmo_cnt == TMO_LAST);

   // Response bytes are handed to the pacer in the same cycle the decision is made.
   always_comb begin
      push_vld = 1'b0;
      push_two = 1'b0;
      push_b0  = RSP_ERR;
      push_b1  = bus.reg_rdata_i;
      case (state)
         S_IDLE: begin
            if (bus.rx_ack_i && !is_opcode(bus.rx_data_i)) begin
               push_vld = 1'b1;
            end
         end
         S_CSUM: begin
            if (bus.rx_ack_i && (bus.rx_data_i != csum_acc)) begin
               push_vld = 1'b1;
            end
         end
         S_EXEC: begin
            if (is_write) begin
               push_vld = 1'b1;
               push_b0  = RSP_OK;
            end
         end
         S_RDWAIT: begin
            push_vld = 1'b1;
            push_two = 1'b1;
            push_b0  = RSP_DATA;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         is_write  <= 1'b0;
         csum_acc  <= '0;
         tmo_cnt   <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
      end else begin
         reg_we <= 1'b0;
         reg_re <= 1'b0;

         if (!in_pkt || bus.rx_ack_i) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (bus.rx_ack_i) begin
                  if (is_opcode(bus.rx_data_i)) begin
                     is_write <= (bus.rx_data_i == OP_WRITE);
                     csum_acc <= bus.rx_data_i;
                     state    <= S_ADDR;
                  end else begin
                     state    <= S_RESP;
                  end
               end
            end
            S_ADDR: begin
               if (bus.rx_ack_i) begin
                  reg_addr <= bus.rx_data_i;
                  csum_acc <= csum_acc ^ bus.rx_data_i;
                  state    <= is_write ? S_DATA : S_CSUM;
               end else if (tmo_exp) begin
                  state    <= S_IDLE;
               end
            end
            S_DATA: begin
               if (bus.rx_ack_i) begin
                  reg_wdata <= bus.rx_data_i;
                  csum_acc  <= csum_acc ^ bus.rx_data_i;
                  state     <= S_CSUM;
               end else if (tmo_exp) begin
                  state     <= S_IDLE;
               end
            end
            S_CSUM: begin
               if (bus.rx_ack_i) begin
                  if (bus.rx_data_i == csum_acc) begin
                     reg_we <= is_write;
                     reg_re <= !is_write;
                     state  <= S_EXEC;
                  end else begin
                     state  <= S_RESP;
                  end
               end else if (tmo_exp) begin
                  state <= S_IDLE;
               end
            end
            S_EXEC:   state <= is_write ? S_RESP : S_RDWAIT;
            S_RDWAIT: state <= S_RESP;
            S_RESP: begin
               if (tx_idle) begin
                  state <= S_IDLE;
               end
            end
            default:  state <= S_IDLE;
         endcase
      end
   end

   uart_tx_pacer #(
      .TX_GAP_CYCLES (TX_GAP_CYCLES)
   ) u_pacer (
      .clk      (clk),
      .rst      (rst),
      .push_vld (push_vld),
      .push_two (push_two),
      .push_b0  (push_b0),
      .push_b1  (push_b1),
      .tx_vld   (tx_vld),
      .tx_dat   (tx_dat),
      .idle     (tx_idle)
   );

   assign bus.tx_ack_o    = tx_vld;
   assign bus.tx_data_o   = tx_dat;
   assign bus.reg_addr_o  = reg_addr;
   assign bus.reg_wdata_o = reg_wdata;
   assign bus.reg_we_o    = reg_we;
   assign bus.reg_re_o    = reg_re;
   assign bus.busy_o      = (state != S_IDLE);

endmodule
